// File: rtl/bshift8_seq_if.sv
// Request/result handshake bundle between a job producer/consumer and bshift8_seq.
interface bshift8_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_data;
  logic [1:0]  req_npass;
  logic [11:0] req_amt;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;

  // Side that offers jobs and takes results.
  modport master (
    output req_valid, req_data, req_npass, req_amt, res_ready,
    input  req_ready, res_valid, res_data
  );

  // The sequencer itself.
  modport slave (
    input  req_valid, req_data, req_npass, req_amt, res_ready,
    output req_ready, res_valid, res_data
  );
endinterface

// File: rtl/bshift8_seq.sv
// Multi-pass sequencer wrapped around an external 8-bit combinational barrel
// shifter: takes a job, runs 1-4 passes through the shifter, returns the word.
module bshift8_seq (
  input  logic             clk,
  input  logic             rst,
  bshift8_seq_if.slave     bus,
  output logic [7:0]       sh_in,
  output logic [2:0]       sh_s,
  input  logic [7:0]       sh_op,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  work_q,  work_d;
  logic [11:0] amt_q,   amt_d;
  logic [1:0]  npass_q, npass_d;
  logic [1:0]  pass_q,  pass_d;

  // State register: every flop clears on synchronous reset, which aborts any job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 8'h00;
      amt_q   <= 12'h000;
      npass_q <= 2'd0;
      pass_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      npass_q <= npass_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic: capture a job in IDLE, fold one shifter pass per RUN cycle, wait for the consumer in DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    amt_d   = amt_q;
    npass_d = npass_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = RUN;
          work_d  = bus.req_data;
          amt_d   = bus.req_amt;
          npass_d = bus.req_npass;
          pass_d  = 2'd0;
        end
      end
      RUN: begin
        work_d = sh_op;
        if (pass_q == npass_q) begin
          state_d = DONE;
        end else begin
          pass_d = pass_q + 2'd1;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registers, so the shifter inputs change only at clock edges.
  always_comb begin
    sh_in         = work_q;
    bus.res_data  = work_q;
    bus.req_ready = (state_q == IDLE);
    bus.res_valid = (state_q == DONE);
    busy          = (state_q != IDLE);
    sh_s          = 3'd0;
    if (state_q == RUN) begin
      case (pass_q)
        2'd0:    sh_s = amt_q[2:0];
        2'd1:    sh_s = amt_q[5:3];
        2'd2:    sh_s = amt_q[8:6];
        default: sh_s = amt_q[11:9];
      endcase
    end
  end

endmodule

// File: tb/tb_bshift8_seq.sv
// Self-checking bench for bshift8_seq: the shifter is modelled as rotate-left,
// a job-level model predicts every output each cycle, directed cases pin literals.
module tb_bshift8_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sh_in;
  logic [2:0] sh_s;
  logic [7:0] sh_op;
  logic       busy;

  int total = 0;
  int bad   = 0;

  bshift8_seq_if bus ();

  bshift8_seq dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .sh_in (sh_in),
    .sh_s  (sh_s),
    .sh_op (sh_op),
    .busy  (busy)
  );

  // Clock with a 10-unit period.
  always #5 clk = ~clk;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] s);
    logic [15:0] t;
    t = {x, x} << s;
    return t[15:8];
  endfunction

  // The bench's stand-in for Bshift8.
  assign sh_op = rotl8(sh_in, sh_s);

  // Word after n passes of a job.
  function automatic logic [7:0] pass_word(input logic [7:0] data, input logic [11:0] amt, input int n);
    logic [7:0] w;
    w = data;
    for (int i = 0; i < n; i++) w = rotl8(w, amt[3*i +: 3]);
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] np,
                               input logic [11:0] a, input logic rdy, input logic r);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_npass = np;
    bus.req_amt   = a;
    bus.res_ready = rdy;
    rst           = r;
  endtask

  // Job-level model: idle, or a job that is m_cyc cycles past its accept edge.
  logic        m_known = 1'b0;
  logic        m_busy  = 1'b0;
  int          m_cyc   = 0;
  logic [7:0]  m_data  = 8'h00;
  logic [11:0] m_amt   = 12'h000;
  int          m_np    = 0;
  logic [7:0]  m_idle_word = 8'h00;

  // Advance the model on each rising edge from the inputs that edge sees.
  always @(posedge clk) begin
    if (rst) begin
      m_known     <= 1'b1;
      m_busy      <= 1'b0;
      m_idle_word <= 8'h00;
    end else if (m_known) begin
      if (!m_busy) begin
        if (bus.req_valid) begin
          m_busy <= 1'b1;
          m_cyc  <= 0;
          m_data <= bus.req_data;
          m_amt  <= bus.req_amt;
          m_np   <= int'(bus.req_npass);
        end
      end else if (m_cyc <= m_np) begin
        m_cyc <= m_cyc + 1;
      end else if (bus.res_ready) begin
        m_busy      <= 1'b0;
        m_idle_word <= pass_word(m_data, m_amt, m_np + 1);
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_known) begin
      if (!m_busy) begin
        checkOutput("idle_req_ready", 12'(bus.req_ready), 12'd1);
        checkOutput("idle_res_valid", 12'(bus.res_valid), 12'd0);
        checkOutput("idle_busy", 12'(busy), 12'd0);
        checkOutput("idle_sh_s", 12'(sh_s), 12'd0);
        checkOutput("idle_sh_in", 12'(sh_in), 12'(m_idle_word));
      end else if (m_cyc <= m_np) begin
        checkOutput("run_req_ready", 12'(bus.req_ready), 12'd0);
        checkOutput("run_res_valid", 12'(bus.res_valid), 12'd0);
        checkOutput("run_busy", 12'(busy), 12'd1);
        checkOutput("run_sh_s", 12'(sh_s), 12'(m_amt[3*m_cyc +: 3]));
        checkOutput("run_sh_in", 12'(sh_in), 12'(pass_word(m_data, m_amt, m_cyc)));
      end else begin
        checkOutput("done_req_ready", 12'(bus.req_ready), 12'd0);
        checkOutput("done_res_valid", 12'(bus.res_valid), 12'd1);
        checkOutput("done_busy", 12'(busy), 12'd1);
        checkOutput("done_sh_s", 12'(sh_s), 12'd0);
        checkOutput("done_res_data", 12'(bus.res_data), 12'(pass_word(m_data, m_amt, m_np + 1)));
      end
    end
  end

  localparam logic [11:0] AMT4 = {3'd7, 3'd3, 3'd2, 3'd1};

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    logic [2:0] exp_s  [4];
    logic [7:0] exp_in [4];
    logic       saw_valid;
    exp_s  = '{3'd1, 3'd2, 3'd3, 3'd7};
    exp_in = '{8'hF0, 8'hE1, 8'h87, 8'h3C};

    bus.req_valid = 1'b0;
    bus.req_data  = 8'h00;
    bus.req_npass = 2'd0;
    bus.req_amt   = 12'h000;
    bus.res_ready = 1'b0;

    // Reset then idle.
    applyStimulus(0, 8'h00, 0, 12'h000, 0, 1);
    applyStimulus(0, 8'h00, 0, 12'h000, 0, 0);
    checkOutput("rst_req_ready", 12'(bus.req_ready), 12'd1);
    checkOutput("rst_res_valid", 12'(bus.res_valid), 12'd0);
    checkOutput("rst_busy", 12'(busy), 12'd0);
    checkOutput("rst_sh_in", 12'(sh_in), 12'h00);
    checkOutput("rst_sh_s", 12'(sh_s), 12'd0);

    // Single pass: F0 rotated by 1.
    applyStimulus(1, 8'hF0, 0, 12'h001, 1, 0);
    applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);
    checkOutput("p1_sh_in", 12'(sh_in), 12'hF0);
    checkOutput("p1_sh_s", 12'(sh_s), 12'd1);
    applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);
    checkOutput("p1_res_valid", 12'(bus.res_valid), 12'd1);
    checkOutput("p1_res_data", 12'(bus.res_data), 12'hE1);

    // Four passes with amounts 1,2,3,7, result held under backpressure.
    applyStimulus(1, 8'hF0, 3, AMT4, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 8'h00, 0, 12'h000, 0, 0);
      checkOutput("p4_sh_s", 12'(sh_s), 12'(exp_s[k]));
      checkOutput("p4_sh_in", 12'(sh_in), 12'(exp_in[k]));
      checkOutput("p4_no_valid_yet", 12'(bus.res_valid), 12'd0);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 8'h55, 1, 12'h0FF, 0, 0);
      checkOutput("bp_res_valid", 12'(bus.res_valid), 12'd1);
      checkOutput("bp_res_data", 12'(bus.res_data), 12'h1E);
      checkOutput("bp_req_ready", 12'(bus.req_ready), 12'd0);
    end
    applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);
    checkOutput("bp_still_done", 12'(bus.res_valid), 12'd1);
    applyStimulus(1, 8'h3C, 1, 12'h009, 1, 0);
    checkOutput("bp_back_idle", 12'(bus.req_ready), 12'd1);
    applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);
    checkOutput("next_job_busy", 12'(busy), 12'd1);
    checkOutput("next_job_sh_in", 12'(sh_in), 12'h3C);
    for (int k = 0; k < 3; k++) applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);

    // Reset during pass 2 of a four-pass job.
    applyStimulus(1, 8'hF0, 3, AMT4, 1, 0);
    applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);
    applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);
    applyStimulus(0, 8'h00, 0, 12'h000, 1, 1);
    applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);
    checkOutput("abort_busy", 12'(busy), 12'd0);
    checkOutput("abort_sh_in", 12'(sh_in), 12'h00);
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);
      saw_valid = saw_valid | bus.res_valid;
    end
    checkOutput("abort_no_result", 12'(saw_valid), 12'd0);

    // Job offered in the same cycle as reset is dropped.
    applyStimulus(1, 8'hA5, 2, 12'h123, 1, 1);
    applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);
    checkOutput("rstjob_busy", 12'(busy), 12'd0);
    checkOutput("rstjob_req_ready", 12'(bus.req_ready), 12'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom),
                    12'($urandom), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 49) == 0));
    end
    applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);
    applyStimulus(0, 8'h00, 0, 12'h000, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
